uart_tx_arbiter: RTL and testbench

//   Shares the single UART transmitter between N_REQ byte requesters using round-robin arbitration.

---
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte requesters.
// Optional feature: define UART_ARB_TIMEOUT_EN to abort frames whose tx ack never arrives.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int GAP_CYC     = 1,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [8*N_REQ-1:0]         data_i,
  output logic [N_REQ-1:0]           ack_o,
  output logic [N_REQ-1:0]           timeout_err_o,
  output logic                       busy_o,
  output logic [$clog2(N_REQ)-1:0]   grant_idx_o,
  output logic                       uart_tx_req_o,
  output logic [7:0]                 uart_tx_data_o,
  input  logic                       uart_tx_ack_i
);

  localparam int IDXW = $clog2(N_REQ);
  localparam int GW   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  state_e          state_q;
  logic [IDXW-1:0] ptr_q;
  logic [GW-1:0]   gapCnt_q;

  logic            winValid_d;
  logic [IDXW-1:0] winIdx_d;
  logic [7:0]      winByte_d;
  logic [IDXW-1:0] ptrNext_d;

  // Scan from the pointer downwards in priority so the closest set bit after ptr wins.
  always_comb begin
    winValid_d = 1'b0;
    winIdx_d   = '0;
    winByte_d  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      int k;
      k = int'(ptr_q) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (req_i[IDXW'(k)]) begin
        winValid_d = 1'b1;
        winIdx_d   = IDXW'(k);
        winByte_d  = 8'(data_i >> (8 * k));
      end
    end
  end

  always_comb begin
    ptrNext_d = (grant_idx_o == IDXW'(N_REQ - 1)) ? '0 : grant_idx_o + 1'b1;
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] sendCnt_q;
  logic          expire_d;
  assign expire_d = (sendCnt_q == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout_err_o = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      gapCnt_q       <= '0;
      ack_o          <= '0;
      busy_o         <= 1'b0;
      grant_idx_o    <= '0;
      uart_tx_req_o  <= 1'b0;
      uart_tx_data_o <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      sendCnt_q      <= '0;
      timeout_err_o  <= '0;
`endif
    end else begin
      ack_o <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_err_o <= '0;
`endif
      unique case (state_q)
        IDLE: begin
          if (winValid_d) begin
            grant_idx_o    <= winIdx_d;
            uart_tx_data_o <= winByte_d;
            uart_tx_req_o  <= 1'b1;
            busy_o         <= 1'b1;
            state_q        <= SEND;
`ifdef UART_ARB_TIMEOUT_EN
            sendCnt_q      <= '0;
`endif
          end
        end
        SEND: begin
          // An ack arriving on the expiry cycle still counts as a normal completion.
          if (uart_tx_ack_i) begin
            ack_o         <= N_REQ'(1) << grant_idx_o;
            uart_tx_req_o <= 1'b0;
            ptr_q         <= ptrNext_d;
            gapCnt_q      <= GW'(GAP_CYC - 1);
            state_q       <= GAP;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (expire_d) begin
            timeout_err_o <= N_REQ'(1) << grant_idx_o;
            uart_tx_req_o <= 1'b0;
            ptr_q         <= ptrNext_d;
            gapCnt_q      <= GW'(GAP_CYC - 1);
            state_q       <= GAP;
          end else begin
            sendCnt_q <= sendCnt_q + 1'b1;
          end
`endif
        end
        GAP: begin
          if (gapCnt_q == '0) begin
            busy_o  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gapCnt_q <= gapCnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a timeline model of grants/acks checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int GAP   = 2;
  localparam int FRAME = 3;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TMO = 50;
`else
  localparam int TMO = 200000;
`endif

  logic         clk = 1'b0;
  logic         rstN = 1'b1;
  logic [3:0]   req = '0;
  logic [31:0]  data = '0;
  logic [3:0]   ackOut;
  logic [3:0]   errOut;
  logic         busy;
  logic [1:0]   grantIdx;
  logic         txReq;
  logic [7:0]   txData;
  logic         txAck;

  logic txAuto = 1'b1;
  logic txAckAuto = 1'b0;
  logic strayAck = 1'b0;
  int   txAge = 0;

  int nChecks = 0;
  int nFails = 0;

  uart_tx_arbiter #(.N_REQ(N), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk), .rst_ni(rstN), .req_i(req), .data_i(data),
    .ack_o(ackOut), .timeout_err_o(errOut), .busy_o(busy), .grant_idx_o(grantIdx),
    .uart_tx_req_o(txReq), .uart_tx_data_o(txData), .uart_tx_ack_i(txAck)
  );

  always #5 clk = ~clk;

  assign txAck = txAckAuto | strayAck;

  function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Transmitter stand-in: acknowledges a frame after it has been requested for FRAME cycles.
  always @(posedge clk) begin
    #1;
    if (txReq && txAuto) begin
      txAge++;
      txAckAuto = (txAge == FRAME);
    end else begin
      txAge = 0;
      txAckAuto = 1'b0;
    end
  end

  // Timeline model: a frame is either in flight or not; arbitration is allowed from cycle mArbCycle.
  int         cyc = 0;
  int         mPtr = 0;
  int         mGrant = 0;
  int         mArbCycle = 0;
  int         mSendStart = 0;
  bit         mActive = 0;
  logic [7:0] mByte = '0;
  logic [3:0] eAck = '0;
  logic [3:0] eErr = '0;
  bit         eBusy = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rstN) begin
      mPtr = 0; mGrant = 0; mArbCycle = 0; mActive = 0; mByte = '0;
      eAck = '0; eErr = '0; eBusy = 0;
    end
    checkOutput("cyc.ack", ackOut, eAck);
    checkOutput("cyc.err", errOut, eErr);
    checkOutput("cyc.busy", busy, eBusy);
    checkOutput("cyc.grant", grantIdx, mGrant);
    checkOutput("cyc.txReq", txReq, mActive);
    checkOutput("cyc.txData", txData, mByte);
    if (rstN) begin
      eAck = '0;
      eErr = '0;
      if (mActive) begin
        if (txAck) begin
          eAck = 4'(1 << mGrant);
          mActive = 0;
          mPtr = (mGrant + 1) % N;
          mArbCycle = cyc + 1 + GAP;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (cyc - mSendStart == TMO - 1) begin
          eErr = 4'(1 << mGrant);
          mActive = 0;
          mPtr = (mGrant + 1) % N;
          mArbCycle = cyc + 1 + GAP;
        end
`endif
      end else if (cyc >= mArbCycle && req != 0) begin
        bit found;
        found = 0;
        for (int i = 0; i < N; i++) begin
          int k;
          k = (mPtr + i) % N;
          if (!found && req[k]) begin
            found = 1;
            mGrant = k;
            mByte = 8'(data >> (8 * k));
            mActive = 1;
            mSendStart = cyc + 1;
          end
        end
      end
      eBusy = mActive || (cyc + 1 < mArbCycle);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitAck(input logic [3:0] expMask, input logic [7:0] expByte, input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (ackOut == 0 && n < 200);
    checkOutput({tag, ".ackMask"}, ackOut, expMask);
    checkOutput({tag, ".byte"}, txData, expByte);
  endtask

  task automatic applyStimulus();
    // Reset held with every requester active
    req = 4'hF;
    data = 32'h13121110;
    #1 rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst.txReq", txReq, 0);
    checkOutput("rst.ack", ackOut, 0);
    checkOutput("rst.busy", busy, 0);
    checkOutput("rst.grant", grantIdx, 0);
    #1 rstN = 1'b1;
    tick();
    checkOutput("rel.txReq", txReq, 1);
    checkOutput("rel.grant", grantIdx, 0);
    checkOutput("rel.data", txData, 8'h10);

    // Round robin across all four, wrapping back to 0
    waitAck(4'b0001, 8'h10, "rr0");
    waitAck(4'b0010, 8'h11, "rr1");
    waitAck(4'b0100, 8'h12, "rr2");
    waitAck(4'b1000, 8'h13, "rr3");
    waitAck(4'b0001, 8'h10, "rr4");
    req = '0;
    repeat (4) tick();

    // Single requester 2; pointer is at 1
    req = 4'b0100;
    data = 32'h00A50000;
    tick();
    checkOutput("single.txReq", txReq, 1);
    checkOutput("single.data", txData, 8'hA5);
    checkOutput("single.grant", grantIdx, 2);
    checkOutput("single.busy", busy, 1);
    waitAck(4'b0100, 8'hA5, "single");
    req = '0;
    checkOutput("gap0.txReq", txReq, 0);
    checkOutput("gap0.busy", busy, 1);
    tick();
    checkOutput("gap1.busy", busy, 1);
    tick();
    checkOutput("gap2.busy", busy, 0);
    checkOutput("gap2.txReq", txReq, 0);

    // Data and req change mid-frame; double-length ack pulse
    txAuto = 1'b0;
    req = 4'b0010;
    data = 32'h00003C00;
    tick();
    checkOutput("hold.grant", grantIdx, 1);
    checkOutput("hold.data0", txData, 8'h3C);
    data = 32'h0000FF00;
    req = '0;
    repeat (4) tick();
    checkOutput("hold.data1", txData, 8'h3C);
    checkOutput("hold.txReq", txReq, 1);
    strayAck = 1'b1;
    tick();
    checkOutput("hold.ack", ackOut, 4'b0010);
    checkOutput("hold.txReqLow", txReq, 0);
    tick();
    checkOutput("hold.ackOnce", ackOut, 0);
    strayAck = 1'b0;
    repeat (3) tick();

    // Reset during a frame; pointer must restart at 0
    req = 4'b1000;
    data = 32'h77000000;
    tick();
    checkOutput("rstmid.grant", grantIdx, 3);
    checkOutput("rstmid.txReq", txReq, 1);
    tick();
    @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("rstmid.txReqAsync", txReq, 0);
    checkOutput("rstmid.busy", busy, 0);
    checkOutput("rstmid.ack", ackOut, 0);
    req = 4'b1010;
    data = 32'h77005500;
    tick();
    @(posedge clk);
    #2 rstN = 1'b1;
    tick();
    checkOutput("rstrel.grant", grantIdx, 1);
    checkOutput("rstrel.data", txData, 8'h55);
    txAuto = 1'b1;
    waitAck(4'b0010, 8'h55, "rstrel1");
    req = 4'b1000;
    waitAck(4'b1000, 8'h77, "rstrel3");
    req = '0;
    repeat (4) tick();

    // Missing transmitter ack
    txAuto = 1'b0;
    req = 4'b0001;
    data = 32'h000000AB;
`ifdef UART_ARB_TIMEOUT_EN
    begin
      int n;
      n = 0;
      do begin
        tick();
        n++;
      end while (errOut == 0 && n < 100);
      checkOutput("tmo.err", errOut, 4'b0001);
      checkOutput("tmo.ack", ackOut, 0);
      checkOutput("tmo.txReq", txReq, 0);
      req = '0;
    end
`else
    repeat (1000) tick();
    checkOutput("noTmo.txReq", txReq, 1);
    checkOutput("noTmo.busy", busy, 1);
    strayAck = 1'b1;
    tick();
    strayAck = 1'b0;
    req = '0;
    checkOutput("noTmo.ack", ackOut, 4'b0001);
`endif
    repeat (4) tick();

    // Ack while idle is ignored
    strayAck = 1'b1;
    tick();
    strayAck = 1'b0;
    repeat (3) tick();
    checkOutput("idleAck.txReq", txReq, 0);
    checkOutput("idleAck.ack", ackOut, 0);
  endtask

  initial begin
    applyStimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got time %0t, expected under 500000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
